// File: rtl/pe_cfg_loader.sv
// Configuration sequencer for a PE array: packs host instruction words into per-context rows,
// commits each row with one init pulse, then issues a single run window. Optional macro: CFG_LOADER_BCAST_EN.
module pe_cfg_loader #(
    parameter int PE_INST_W = 48,
    parameter int NUM_PE    = 16,
    parameter int DEPTH     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start,
    input  logic [5:0]                  cfg_ctx_num,
`ifdef CFG_LOADER_BCAST_EN
    input  logic                        cfg_bcast,
`endif
    input  logic                        run_start,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [PE_INST_W-1:0]        s_data,
    output logic                        pe_rst,
    output logic                        pe_init,
    output logic                        pe_run,
    output logic [NUM_PE*PE_INST_W-1:0] pe_inst,
    output logic                        busy,
    output logic                        loaded,
    output logic                        done,
    output logic                        err
);

    localparam int SLOT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int ROW_W  = NUM_PE * PE_INST_W;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COMMIT, READY, RUN} state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [5:0]          ctx_q, ctx_d;
    logic [5:0]          num_q, num_d;
    logic [5:0]          run_cnt_q, run_cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROW_W-1:0]    inst_q, inst_d;
    logic                bcast_q;
    logic                rst_q, init_q, run_q, busy_q, loaded_q, done_q, err_q;
    logic                rst_d, init_d, run_d, busy_d, loaded_d, done_d, err_d;

`ifdef CFG_LOADER_BCAST_EN
    logic                bcast_d;
`else
    assign bcast_q = 1'b0;
`endif

    function automatic logic legal_count(input logic [5:0] n);
        return (n != 6'd0) && (int'(n) <= DEPTH);
    endfunction

    // Broadcast mode replicates the single beat into every slot of the row.
    function automatic logic [ROW_W-1:0] write_slot(input logic [ROW_W-1:0]     row,
                                                    input logic [SLOT_W-1:0]    slot,
                                                    input logic [PE_INST_W-1:0] data,
                                                    input logic                 bcast);
        logic [ROW_W-1:0] r;
        if (bcast) begin
            r = {NUM_PE{data}};
        end else begin
            r = row;
            r[int'(slot)*PE_INST_W +: PE_INST_W] = data;
        end
        return r;
    endfunction

    assign s_ready = (state_q == LOAD);

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        ctx_d     = ctx_q;
        num_d     = num_q;
        run_cnt_d = run_cnt_q;
        row_d     = row_q;
        inst_d    = inst_q;
        err_d     = 1'b0;
        done_d    = 1'b0;
`ifdef CFG_LOADER_BCAST_EN
        bcast_d   = bcast_q;
`endif
        unique case (state_q)
            IDLE, READY: begin
                if ((state_q == READY) && run_start) begin
                    state_d   = RUN;
                    run_cnt_d = 6'd0;
                end else if (load_start) begin
                    if (legal_count(cfg_ctx_num)) begin
                        num_d   = cfg_ctx_num;
                        slot_d  = '0;
                        ctx_d   = 6'd0;
                        state_d = CLEAR;
`ifdef CFG_LOADER_BCAST_EN
                        bcast_d = cfg_bcast;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: state_d = LOAD;
            LOAD: begin
                if (s_valid) begin
                    row_d  = write_slot(row_q, slot_q, s_data, bcast_q);
                    slot_d = slot_q + SLOT_W'(1);
                    if (bcast_q || (slot_q == SLOT_W'(NUM_PE - 1))) begin
                        state_d = COMMIT;
                        inst_d  = row_d;
                    end
                end
            end
            COMMIT: begin
                ctx_d   = ctx_q + 6'd1;
                slot_d  = '0;
                state_d = ((ctx_q + 6'd1) == num_q) ? READY : LOAD;
            end
            RUN: begin
                // Run window of num_q cycles, then one extra cycle carrying done.
                run_cnt_d = run_cnt_q + 6'd1;
                if (run_cnt_q == num_q)
                    state_d = IDLE;
                else if ((run_cnt_q + 6'd1) == num_q)
                    done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        rst_d    = (state_d == CLEAR);
        init_d   = (state_d == COMMIT);
        run_d    = (state_d == RUN) && !done_d;
        busy_d   = (state_d != IDLE) && (state_d != READY);
        loaded_d = (state_d == READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            ctx_q     <= 6'd0;
            num_q     <= 6'd0;
            run_cnt_q <= 6'd0;
            row_q     <= '0;
            inst_q    <= '0;
            rst_q     <= 1'b0;
            init_q    <= 1'b0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            loaded_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            ctx_q     <= ctx_d;
            num_q     <= num_d;
            run_cnt_q <= run_cnt_d;
            row_q     <= row_d;
            inst_q    <= inst_d;
            rst_q     <= rst_d;
            init_q    <= init_d;
            run_q     <= run_d;
            busy_q    <= busy_d;
            loaded_q  <= loaded_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef CFG_LOADER_BCAST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcast_q <= 1'b0;
        else        bcast_q <= bcast_d;
    end
`endif

    assign pe_rst  = rst_q;
    assign pe_init = init_q;
    assign pe_run  = run_q;
    assign pe_inst = inst_q;
    assign busy    = busy_q;
    assign loaded  = loaded_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Directed bench for pe_cfg_loader with a row/event model and a per-cycle compare process.
module tb_pe_cfg_loader;
    localparam int NPE  = 4;
    localparam int IW   = 8;
    localparam int ROWW = NPE * IW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load_start = 1'b0;
    logic [5:0]      cfg_ctx_num = 6'd0;
    logic            cfg_bcast = 1'b0;
    logic            run_start = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [IW-1:0]   s_data = '0;
    logic            pe_rst, pe_init, pe_run, busy, loaded, done, err;
    logic [ROWW-1:0] pe_inst;

    pe_cfg_loader #(.PE_INST_W(IW), .NUM_PE(NPE), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .cfg_ctx_num(cfg_ctx_num),
`ifdef CFG_LOADER_BCAST_EN
        .cfg_bcast(cfg_bcast),
`endif
        .run_start(run_start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .pe_rst(pe_rst), .pe_init(pe_init), .pe_run(pe_run), .pe_inst(pe_inst),
        .busy(busy), .loaded(loaded), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_rst = 0, n_init = 0, n_run = 0, n_done = 0, n_err = 0;
    int beats_seen = 0, inits_seen = 0;
    bit bcast_mode = 1'b0;
    logic [ROWW-1:0] exp_rows[$];
    logic [ROWW-1:0] seen_rows[$];
    logic [ROWW-1:0] prev_inst = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] beat(input int base, input int idx);
        return IW'(base + idx + 1);
    endfunction

    // Compare process: every committed row must match the model, in order.
    always @(negedge clk) begin
        if (rst_n) begin
            n_rst  += int'(pe_rst);
            n_run  += int'(pe_run);
            n_done += int'(done);
            n_err  += int'(err);
            if (s_valid && s_ready) beats_seen++;
            if (pe_init) begin
                n_init++;
                inits_seen++;
                check("beats_before_init", beats_seen, bcast_mode ? inits_seen : inits_seen * NPE);
                if (exp_rows.size() == 0) check("row_unexpected", 1, 0);
                else                      check("row", pe_inst, exp_rows.pop_front());
                seen_rows.push_back(pe_inst);
            end else begin
                check("inst_stable", pe_inst, prev_inst);
            end
            check("init_excl", pe_init && (pe_rst || pe_run), 0);
            check("loaded_busy_excl", loaded && busy, 0);
        end
        prev_inst = pe_inst;
    end

    task automatic do_load(input int n, input int base, input bit bc, input bit stall, output int lat);
        int total, idx, cyc, r0;
        bit sv, acc;
        logic [ROWW-1:0] row;
        total = bc ? n : n * NPE;
        for (int c = 0; c < n; c++) begin
            row = '0;
            for (int k = 0; k < NPE; k++)
                row[k*IW +: IW] = bc ? beat(base, c) : beat(base, c * NPE + k);
            exp_rows.push_back(row);
        end
        r0 = n_rst;
        beats_seen = 0; inits_seen = 0; bcast_mode = bc;
        load_start = 1'b1; cfg_ctx_num = 6'(n); cfg_bcast = bc;
        @(posedge clk); #1;
        load_start = 1'b0;
        cyc = 0; idx = 0; lat = -1;
        check("rst_pulse", pe_rst, 1);
        while (cyc < 300 && lat < 0) begin
            if (cyc == 1) check("ready_latency", s_ready, 1);
            sv = (idx < total) && (!stall || (cyc % 2 == 0));
            s_valid = sv;
            s_data = beat(base, idx);
            acc = sv && s_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (loaded) lat = cyc;
        end
        s_valid = 1'b0;
        check("load_beats", idx, total);
        check("load_completed", lat >= 0, 1);
        check("rows_all_committed", exp_rows.size(), 0);
        check("rst_pulse_count", n_rst - r0, 1);
    endtask

    task automatic do_run(input int n);
        check("pre_run_loaded", loaded, 1);
        run_start = 1'b1;
        @(posedge clk); #1;
        run_start = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            check("run_window", pe_run, k <= n);
            check("run_done", done, k == n + 1);
            check("run_busy", busy, k <= n + 1);
            @(posedge clk); #1;
        end
        check("post_run_loaded", loaded, 0);
    endtask

    task automatic do_illegal(input int v);
        int r0, e0;
        r0 = n_rst; e0 = n_err;
        load_start = 1'b1; cfg_ctx_num = 6'(v);
        @(posedge clk); #1;
        load_start = 1'b0;
        check("err_pulse", err, 1);
        check("err_no_rst", pe_rst, 0);
        check("err_not_busy", busy, 0);
        @(posedge clk); #1;
        check("err_one_cycle", err, 0);
        check("err_stay_idle", busy | loaded | s_ready, 0);
        check("err_count", n_err - e0, 1);
        check("err_rst_count", n_rst - r0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, s0, q0, got;
        bit acc;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {pe_rst, pe_init, pe_run, busy, loaded, done, err, s_ready}, 0);
        check("reset_inst", pe_inst, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Scenario 1: legal load, two contexts, no stalls
        s0 = n_init;
        do_load(2, 0, 1'b0, 1'b0, lat);
        check("s1_loaded_latency", lat, 11);
        check("s1_init_count", n_init - s0, 2);
        check("s1_row0_literal", seen_rows[0], 32'h04030201);
        check("s1_row1_literal", seen_rows[1], 32'h08070605);

        // Scenario 2: reload from READY with back-pressure
        do_load(2, 0, 1'b0, 1'b1, lat);
        check("s2_slower", lat > 11, 1);
        check("s2_row0_literal", seen_rows[2], 32'h04030201);
        check("s2_row1_literal", seen_rows[3], 32'h08070605);

        // Scenario 3: run, then a second run_start is ignored
        do_run(2);
        s0 = n_run;
        run_start = 1'b1;
        @(posedge clk); #1;
        run_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rerun_ignored", n_run - s0, 0);
        check("rerun_idle", busy | loaded | done, 0);

        // Scenario 4: illegal counts
        do_illegal(0);
        do_illegal(33);

        // Scenario 5: async reset mid-load after two beats
        beats_seen = 0; inits_seen = 0; bcast_mode = 1'b0;
        load_start = 1'b1; cfg_ctx_num = 6'd2;
        @(posedge clk); #1;
        load_start = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            s_valid = 1'b1; s_data = IW'(8'h55 + got);
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) got++;
        end
        s_valid = 1'b0;
        check("s5_beats_before_reset", got, 2);
        #2 rst_n = 1'b0;
        #1;
        check("s5_reset_outputs", {pe_rst, pe_init, pe_run, busy, loaded, done, err, s_ready}, 0);
        check("s5_reset_inst", pe_inst, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        q0 = seen_rows.size();
        do_load(1, 8'h20, 1'b0, 1'b0, lat);
        check("s5_reload_latency", lat, 6);
        check("s5_row_literal", seen_rows[q0], 32'h24232221);
        do_run(1);

`ifdef CFG_LOADER_BCAST_EN
        // Scenario 6: broadcast, one beat per context
        q0 = seen_rows.size();
        do_load(3, 9, 1'b1, 1'b0, lat);
        check("s6_loaded_latency", lat, 7);
        check("s6_row0_literal", seen_rows[q0], 32'h0A0A0A0A);
        check("s6_row1_literal", seen_rows[q0+1], 32'h0B0B0B0B);
        check("s6_row2_literal", seen_rows[q0+2], 32'h0C0C0C0C);
        do_run(3);
        cfg_bcast = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
